// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} pairs from the fetch unit,
// throttles/steers the PC, and hands entries to decode via valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        fetch_enable,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [31:0] r_pc_mem    [DEPTH];
  logic [31:0] r_instr_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_push;

  // Handshake decode, PC steering and head read-out
  always_comb begin
    out_valid    = (r_count != '0);
    w_pop        = out_valid & out_ready;
    // A full queue still accepts a push when the head leaves this cycle
    w_push       = !redirect & ((r_count < CNT_FULL) | w_pop);
    fetch_enable = reset & (redirect | w_push);
    if (!reset)
      next_pc = RESET_PC;
    else if (redirect)
      next_pc = {redirect_pc[31:2], 2'b00};
    else
      next_pc = fetch_pc + 32'd4;
    out_instr    = r_instr_mem[r_rd];
    out_pc       = r_pc_mem[r_rd];
  end

  // Queue storage, pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr]    <= fetch_pc;
        r_instr_mem[r_wr] <= fetch_instr;
        r_wr              <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
